// File: rtl/udp_tx_packetizer.sv
// Collects a byte stream into one datagram buffer, then emits a UDP header beat followed by the payload.
// A datagram closes when the buffer is full or the input has been idle for TIMEOUT_CYCLES.
// Input is stalled from close until the last payload byte is accepted; the header and payload beats hold under backpressure.
module udp_tx_packetizer #(
    parameter int          MAX_PAYLOAD    = 64,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [31:0] SOURCE_IP      = {8'd192, 8'd168, 8'd1, 8'd128},
    parameter logic [31:0] DEST_IP        = {8'd192, 8'd168, 8'd1, 8'd127},
    parameter logic [15:0] SOURCE_PORT    = 16'd3001,
    parameter logic [15:0] DEST_PORT      = 16'd3000
) (
    input  logic        udp_sys_clk,
    input  logic        system_reset,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [15:0] hdr_length,
    output logic [31:0] hdr_source_ip,
    output logic [31:0] hdr_dest_ip,
    output logic [15:0] hdr_source_port,
    output logic [15:0] hdr_dest_port,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic [15:0] pkt_count
);

    localparam int            AW       = $clog2(MAX_PAYLOAD);
    localparam int            CW       = AW + 1;
    localparam int            TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_PAYLOAD);
    localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT_CYCLES);
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   hdr_length_q, hdr_length_d;
    logic [15:0]   pkt_count_q, pkt_count_d;
    logic          s_tready_q, s_tready_d;
    logic [7:0]    m_tdata_q, m_tdata_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          m_tlast_q, m_tlast_d;

    logic [7:0]    mem [MAX_PAYLOAD];

    logic          s_accept;
    logic          m_fire;
    logic          last_fire;
    logic          rd_load;
    logic          fill_close;

    assign s_accept  = s_tvalid && s_tready_q;
    assign m_fire    = m_tvalid_q && m_tready;
    assign last_fire = m_fire && m_tlast_q;
    assign rd_load   = (state_q == ST_SEND) && (rd_ptr_q < count_q) && (!m_tvalid_q || m_tready);

    // State register
    always_ff @(posedge udp_sys_clk) begin
        if (system_reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (fill_close) state_d = ST_HDR;
            ST_HDR:  if (hdr_ready)  state_d = ST_SEND;
            ST_SEND: if (last_fire)  state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    // Output logic
    always_comb begin
        hdr_valid = (state_q == ST_HDR);
    end

    assign s_tready        = s_tready_q;
    assign hdr_length      = hdr_length_q;
    assign m_tdata         = m_tdata_q;
    assign m_tvalid        = m_tvalid_q;
    assign m_tlast         = m_tlast_q;
    assign m_tuser         = 1'b0;
    assign pkt_count       = pkt_count_q;
    assign hdr_source_ip   = SOURCE_IP;
    assign hdr_dest_ip     = DEST_IP;
    assign hdr_source_port = SOURCE_PORT;
    assign hdr_dest_port   = DEST_PORT;

    always_comb begin
        count_d      = count_q;
        timer_d      = timer_q;
        rd_ptr_d     = rd_ptr_q;
        hdr_length_d = hdr_length_q;
        pkt_count_d  = pkt_count_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        fill_close   = 1'b0;

        if (state_q == ST_FILL) begin
            if (s_accept) begin
                count_d = count_q + CW'(1);
                timer_d = '0;
            end else if ((count_q != '0) && (timer_q != TMO_LIM)) begin
                timer_d = timer_q + TW'(1);
            end
            if (count_d == CNT_FULL) begin
                fill_close = 1'b1;
            end
            // Idle close fires on the cycle whose increment brings the timer to the limit.
            if (TMO_EN && (count_q != '0) && !s_accept && (timer_d == TMO_LIM)) begin
                fill_close = 1'b1;
            end
            if (fill_close) begin
                hdr_length_d = 16'(count_d) + 16'd8;
            end
        end

        if (state_q == ST_SEND) begin
            // The RAM read lands directly in the output register, so a new byte
            // is fetched whenever the register is empty or being drained.
            if (rd_load) begin
                m_tdata_d  = mem[rd_ptr_q[AW-1:0]];
                m_tvalid_d = 1'b1;
                m_tlast_d  = (rd_ptr_q == (count_q - CW'(1)));
                rd_ptr_d   = rd_ptr_q + CW'(1);
            end else if (m_fire) begin
                m_tvalid_d = 1'b0;
                m_tlast_d  = 1'b0;
            end
            if (last_fire) begin
                count_d     = '0;
                timer_d     = '0;
                rd_ptr_d    = '0;
                pkt_count_d = pkt_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        s_tready_d = (state_d == ST_FILL) && (count_d < CNT_FULL);
    end

    always_ff @(posedge udp_sys_clk) begin
        if (system_reset) begin
            count_q      <= '0;
            timer_q      <= '0;
            rd_ptr_q     <= '0;
            hdr_length_q <= '0;
            pkt_count_q  <= '0;
            s_tready_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            timer_q      <= timer_d;
            rd_ptr_q     <= rd_ptr_d;
            hdr_length_q <= hdr_length_d;
            pkt_count_q  <= pkt_count_d;
            s_tready_q   <= s_tready_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
        end
    end

    always_ff @(posedge udp_sys_clk) begin
        if ((state_q == ST_FILL) && s_accept) begin
            mem[count_q[AW-1:0]] <= s_tdata;
        end
    end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Bench for udp_tx_packetizer: three instances (4/no timeout, 64/10, 64/5) share inputs; one is observed at a time.
module tb_udp_tx_packetizer;

    localparam int          TMO_SLACK = 1;
    localparam logic [31:0] EXP_SIP   = 32'hC0A8_0180;
    localparam logic [31:0] EXP_DIP   = 32'hC0A8_017F;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       = 1'b1;
    logic [7:0] s_tdata   = 8'h00;
    logic       s_tvalid  = 1'b0;
    logic       hdr_ready = 1'b0;
    logic       m_tready  = 1'b0;
    logic [1:0] sel       = 2'd0;
    logic       bp        = 1'b0;

    logic        s_tready_w   [3];
    logic        hdr_valid_w  [3];
    logic [15:0] hdr_length_w [3];
    logic [31:0] sip_w        [3];
    logic [31:0] dip_w        [3];
    logic [15:0] sport_w      [3];
    logic [15:0] dport_w      [3];
    logic [7:0]  m_tdata_w    [3];
    logic        m_tvalid_w   [3];
    logic        m_tlast_w    [3];
    logic        m_tuser_w    [3];
    logic [15:0] pkt_count_w  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        udp_tx_packetizer #(
            .MAX_PAYLOAD   (g == 0 ? 4 : 64),
            .TIMEOUT_CYCLES(g == 0 ? 0 : (g == 1 ? 10 : 5))
        ) u_dut (
            .udp_sys_clk    (clk),
            .system_reset   (rst),
            .s_tdata        (s_tdata),
            .s_tvalid       (s_tvalid),
            .s_tready       (s_tready_w[g]),
            .hdr_valid      (hdr_valid_w[g]),
            .hdr_ready      (hdr_ready),
            .hdr_length     (hdr_length_w[g]),
            .hdr_source_ip  (sip_w[g]),
            .hdr_dest_ip    (dip_w[g]),
            .hdr_source_port(sport_w[g]),
            .hdr_dest_port  (dport_w[g]),
            .m_tdata        (m_tdata_w[g]),
            .m_tvalid       (m_tvalid_w[g]),
            .m_tready       (m_tready),
            .m_tlast        (m_tlast_w[g]),
            .m_tuser        (m_tuser_w[g]),
            .pkt_count      (pkt_count_w[g])
        );
    end

    logic        s_tready, hdr_valid, m_tvalid, m_tlast, m_tuser;
    logic [15:0] hdr_length, pkt_count, sport, dport;
    logic [31:0] sip, dip;
    logic [7:0]  m_tdata;
    always_comb begin
        s_tready   = s_tready_w[sel];
        hdr_valid  = hdr_valid_w[sel];
        hdr_length = hdr_length_w[sel];
        sip        = sip_w[sel];
        dip        = dip_w[sel];
        sport      = sport_w[sel];
        dport      = dport_w[sel];
        m_tdata    = m_tdata_w[sel];
        m_tvalid   = m_tvalid_w[sel];
        m_tlast    = m_tlast_w[sel];
        m_tuser    = m_tuser_w[sel];
        pkt_count  = pkt_count_w[sel];
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]  tx[$];
    logic [7:0]  cur[$];
    logic [15:0] exp_len[$];
    logic [8:0]  exp_beats[$];
    logic [15:0] got_len[$];
    logic [8:0]  got_beats[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: records handshakes and checks hold/stall rules on the observed instance.
    logic       prev_h_stall = 1'b0;
    logic       prev_m_stall = 1'b0;
    logic [15:0] prev_len;
    logic [8:0]  prev_beat;
    always @(negedge clk) begin
        if (rst) begin
            prev_h_stall = 1'b0;
            prev_m_stall = 1'b0;
        end else begin
            if (prev_h_stall) begin
                chk("hdr_hold_valid", 32'(hdr_valid), 32'd1);
                chk("hdr_hold_length", 32'(hdr_length), 32'(prev_len));
            end
            if (prev_m_stall) begin
                chk("m_hold_valid", 32'(m_tvalid), 32'd1);
                chk("m_hold_beat", 32'({m_tlast, m_tdata}), 32'(prev_beat));
            end
            if (hdr_valid || m_tvalid) chk("no_input_while_busy", 32'(s_tready), 32'd0);
            if (hdr_valid && hdr_ready) got_len.push_back(hdr_length);
            if (m_tvalid && m_tready) got_beats.push_back({m_tlast, m_tdata});
            prev_h_stall = hdr_valid && !hdr_ready;
            prev_len     = hdr_length;
            prev_m_stall = m_tvalid && !m_tready;
            prev_beat    = {m_tlast, m_tdata};
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (bp) begin
            m_tready  = 1'($urandom_range(0, 1));
            hdr_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        tx.push_back(b);
        cur.push_back(b);
    endtask

    // Reference: a closed datagram of n bytes yields length n+8 and n beats, tlast on the final one.
    task automatic expect_cur();
        exp_len.push_back(16'(cur.size() + 8));
        for (int i = 0; i < cur.size(); i++) exp_beats.push_back({(i == cur.size() - 1), cur[i]});
        cur.delete();
    endtask

    task automatic drive_tx(input int max_gap);
        int   idx   = 0;
        int   gap   = 0;
        int   guard = 0;
        logic take;
        while (idx < tx.size() && guard < 4000) begin
            if (gap > 0) begin
                s_tvalid = 1'b0;
                gap--;
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = tx[idx];
            end
            take = s_tvalid && s_tready;
            cycle();
            guard++;
            if (take) begin
                idx++;
                gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            end
        end
        s_tvalid = 1'b0;
        chk("bytes_accepted", 32'(idx), 32'(tx.size()));
        tx.delete();
    endtask

    task automatic wait_pkts(input int n);
        int guard = 0;
        while (pkt_count != 16'(n) && guard < 3000) begin
            cycle();
            guard++;
        end
        chk("pkt_count", 32'(pkt_count), 32'(n));
    endtask

    task automatic compare_all();
        chk("hdr_count", 32'(got_len.size()), 32'(exp_len.size()));
        for (int i = 0; i < exp_len.size() && i < got_len.size(); i++)
            chk("hdr_length", 32'(got_len[i]), 32'(exp_len[i]));
        chk("beat_count", 32'(got_beats.size()), 32'(exp_beats.size()));
        for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++)
            chk("beat_tlast_data", 32'(got_beats[i]), 32'(exp_beats[i]));
        got_len.delete();
        got_beats.delete();
        exp_len.delete();
        exp_beats.delete();
    endtask

    task automatic do_reset(input logic [1:0] new_sel);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        sel      = new_sel;
        cycle();
        cycle();
        rst = 1'b0;
        got_len.delete();
        got_beats.delete();
        exp_len.delete();
        exp_beats.delete();
        cur.delete();
        tx.delete();
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;

        // Reset values, constant header fields during reset
        rst = 1'b1;
        sel = 2'd0;
        cycle();
        cycle();
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("rst_hdr_length", 32'(hdr_length), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("src_ip", sip, EXP_SIP);
        chk("dst_ip", dip, EXP_DIP);
        chk("src_port", 32'(sport), 32'd3001);
        chk("dst_port", 32'(dport), 32'd3000);
        chk("m_tuser", 32'(m_tuser), 32'd0);
        rst = 1'b0;
        cycle();
        chk("fill_after_reset", 32'(s_tready), 32'd1);

        // Full-buffer close, MAX_PAYLOAD=4
        do_reset(2'd0);
        hdr_ready = 1'b1;
        m_tready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            add_byte(8'(i));
            if (cur.size() == 4) expect_cur();
        end
        drive_tx(0);
        wait_pkts(2);
        compare_all();

        // Idle-timeout close, TIMEOUT=10
        do_reset(2'd1);
        add_byte(8'hA1);
        add_byte(8'hA2);
        add_byte(8'hA3);
        expect_cur();
        drive_tx(0);
        k = 0;
        while (!hdr_valid && k < 200) begin
            cycle();
            k++;
        end
        chk("timeout_latency_in_window", 32'((k >= 10 - TMO_SLACK) && (k <= 10 + TMO_SLACK)), 32'd1);
        wait_pkts(1);
        compare_all();

        // Single byte, TIMEOUT=5
        do_reset(2'd2);
        add_byte(8'h5A);
        expect_cur();
        drive_tx(0);
        wait_pkts(1);
        compare_all();

        // Header backpressure for 20 cycles
        hdr_ready = 1'b0;
        add_byte(8'hC3);
        add_byte(8'h3C);
        expect_cur();
        drive_tx(0);
        k = 0;
        while (!hdr_valid && k < 200) begin
            cycle();
            k++;
        end
        chk("hdr_wait", 32'(hdr_valid), 32'd1);
        chk("hdr_len_stalled", 32'(hdr_length), 32'd10);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("stall_hdr_valid", 32'(hdr_valid), 32'd1);
            chk("stall_hdr_length", 32'(hdr_length), 32'd10);
            chk("stall_s_tready", 32'(s_tready), 32'd0);
            chk("stall_m_tvalid", 32'(m_tvalid), 32'd0);
        end
        hdr_ready = 1'b1;
        wait_pkts(2);
        compare_all();

        // Random backpressure: one full 64-byte datagram, then random partial ones
        do_reset(2'd1);
        bp = 1'b1;
        for (int i = 0; i < 64; i++) add_byte(8'($urandom));
        expect_cur();
        drive_tx(2);
        wait_pkts(1);
        compare_all();
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 63));
            for (int i = 0; i < n; i++) add_byte(8'($urandom));
            expect_cur();
            drive_tx(3);
            wait_pkts(r + 2);
            compare_all();
        end
        bp        = 1'b0;
        hdr_ready = 1'b1;
        m_tready  = 1'b1;

        // Reset in the middle of SEND
        do_reset(2'd1);
        for (int i = 0; i < 20; i++) tx.push_back(8'(8'h40 + i));
        drive_tx(0);
        k = 0;
        while (got_beats.size() < 10 && k < 200) begin
            cycle();
            k++;
        end
        chk("reached_byte10", 32'(got_beats.size() >= 10), 32'd1);
        rst = 1'b1;
        cycle();
        chk("mid_rst_s_tready", 32'(s_tready), 32'd0);
        chk("mid_rst_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("mid_rst_hdr_length", 32'(hdr_length), 32'd0);
        chk("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("mid_rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
        rst = 1'b0;
        got_len.delete();
        got_beats.delete();
        cycle();
        for (int i = 0; i < 4; i++) add_byte(8'(8'h90 + i));
        expect_cur();
        drive_tx(0);
        wait_pkts(1);
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_tx_packetizer.md
Name: udp_tx_packetizer

Overview:
Store-and-forward packetizer upstream of udp_complete_wrapper's transmit side. It accepts a continuous byte stream and collects bytes into one datagram buffer. It closes a datagram when the buffer is full or when the input has been idle for a set time. For each datagram it emits one UDP header beat with the correct udp_length, then the payload with exact tlast framing. This replaces free-running payload sources, which have no length/tlast relationship.

Parameters:
MAX_PAYLOAD, 64, maximum payload bytes per datagram; power of two, 2..1024.
TIMEOUT_CYCLES, 1000, idle cycles after last accepted byte before a partial datagram closes; 0 disables the timeout.
SOURCE_IP, {8'd192,8'd168,8'd1,8'd128}, driven on hdr_source_ip.
DEST_IP, {8'd192,8'd168,8'd1,8'd127}, driven on hdr_dest_ip.
SOURCE_PORT, 3001, driven on hdr_source_port.
DEST_PORT, 3000, driven on hdr_dest_port.

Ports:
udp_sys_clk  in  1  clock
system_reset  in  1  synchronous, active-high reset
s_tdata  in  8  input byte stream
s_tvalid  in  1  input valid
s_tready  out  1  input ready
hdr_valid  out  1  UDP header valid (to udp_in.udp_hdr_valid)
hdr_ready  in  1  UDP header ready
hdr_length  out  16  payload bytes + 8
hdr_source_ip  out  32  SOURCE_IP, constant
hdr_dest_ip  out  32  DEST_IP, constant
hdr_source_port  out  16  SOURCE_PORT, constant
hdr_dest_port  out  16  DEST_PORT, constant
m_tdata  out  8  payload byte
m_tvalid  out  1  payload valid
m_tready  in  1  payload ready
m_tlast  out  1  last payload byte of datagram
m_tuser  out  1  tied 0
pkt_count  out  16  datagrams fully sent; wraps 0xFFFF->0

Behaviour:
- Reset values: s_tready=0, hdr_valid=0, hdr_length=0, m_tvalid=0, m_tlast=0, m_tdata=0, pkt_count=0. Internal state: FILL, byte count=0, idle timer=0.
- A reset asserted in any state discards the buffered datagram. The cycle after reset deasserts is FILL with the buffer empty.
- Buffer: MAX_PAYLOAD x 8 RAM, write index = byte count. Count width is clog2(MAX_PAYLOAD)+1.
- FILL state:
  - s_tready=1 while count<MAX_PAYLOAD.
  - Each s_tvalid&&s_tready writes the byte at index count, increments count, and clears the idle timer.
  - If count>0 and no byte is accepted this cycle, the idle timer increments, saturating.
  - Close when count reaches MAX_PAYLOAD, including the cycle the final byte is accepted. s_tready drops the next cycle.
  - Close when TIMEOUT_CYCLES!=0, count>0 and the timer reaches TIMEOUT_CYCLES.
  - On close: latch hdr_length=count+8 (16-bit) and go to HDR.
  - count==0 never closes; empty datagrams are never emitted.
- HDR state:
  - s_tready=0, hdr_valid=1, hdr_length held stable.
  - On hdr_valid&&hdr_ready, go to SEND.
- SEND state:
  - s_tready=0; hdr_valid is 0 from the cycle after the header handshake.
  - m_tvalid rises no later than 2 cycles after entering SEND.
  - Bytes are sent in write order from index 0 to count-1.
  - With m_tready held high, bytes go out back-to-back with no bubbles (prefetch the RAM read).
  - m_tdata/m_tvalid/m_tlast hold while m_tvalid&&!m_tready.
  - m_tlast=1 only on byte count-1; a 1-byte datagram has m_tlast on its only byte.
  - On the handshake with m_tlast=1: pkt_count+1, count=0, timer=0, go to FILL. s_tready is 1 the next cycle.
- No overlap: input is stalled from close until the datagram's last byte is sent.
- The constant header fields are driven continuously from parameters, including during reset.

Test Plan:
- MAX_PAYLOAD=4, TIMEOUT=0. Stream 0x00..0x07 with m_tready=1, hdr_ready=1 -> two headers with hdr_length=12; payloads 00 01 02 03 and 04 05 06 07, tlast on 03 and 07; pkt_count=2.
- MAX_PAYLOAD=64, TIMEOUT=10. Send 3 bytes A1 A2 A3, then idle -> hdr_valid rises 10 idle cycles after A3 is accepted (±1 implementation cycle allowed by a documented constant); hdr_length=11; tlast on A3.
- Single byte 0x5A, then idle with TIMEOUT=5 -> hdr_length=9; one beat 0x5A with m_tlast=1.
- hdr_ready held 0 for 20 cycles -> hdr_valid and hdr_length stay stable; s_tready=0; m_tvalid=0. After hdr_ready=1, the payload follows.
- Random m_tready backpressure (50%) on a 64-byte datagram -> data held stable while stalled; all 64 bytes arrive in order; exactly one tlast; no input accepted during HDR/SEND.
- Assert system_reset mid-SEND after byte 10 -> next cycle all outputs are at reset values and pkt_count is unchanged from 0. A new 4-byte stream then produces a clean datagram with hdr_length=12.
